rr_tdm_mult_engine: RTL and testbench

Parametrised time-division-multiplexed multiply engine. It services NUM_CH input channels in mask-aware round-robin order, one per clock. Each granted sample is multiplied by that channel's own wrapping coefficient counter, and the product is emitted through a DSP48-mappable pipeline tagged with channel number and valid. It replaces the fixed two-input round-robin mux, shared incrementer and multiplier chain at the design top level.

---
 rtl/rr_tdm_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/rr_tdm_mult_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_rr_tdm_mult_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_tdm_pkg.sv
// rtl/rr_tdm_pkg.sv - shared types and helpers for the round-robin TDM multiply engine
package rr_tdm_pkg;

    // Widest channel tag carried in the pipeline (NUM_CH up to 16).
    localparam int TAG_MAX_W = 4;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    typedef logic [TAG_MAX_W-1:0] ch_tag_t;

    // Bubble/valid record travelling alongside the data path.
    typedef struct packed {
        logic    valid;
        ch_tag_t tag;
    } pipe_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - mask-aware round-robin grant with its rotating pointer
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [CH_W-1:0]   grant,
    output logic              grant_valid
);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;
    logic            found;
    int              idx;
    int              nxt;

    assign grant_valid = en & (|ch_en);

    // Pick the first enabled channel at or after ptr, wrapping past NUM_CH-1.
    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && ch_en[CH_W'(idx)]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

    // Move the pointer just past the granted channel; bubbles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        nxt   = int'(grant) + 1;
        if (grant_valid) begin
            ptr_d = (nxt >= NUM_CH) ? '0 : CH_W'(nxt);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_tdm_mult_engine.sv
// rtl/rr_tdm_mult_engine.sv - round-robin TDM multiplier with per-channel coefficient counters
module rr_tdm_mult_engine
    import rr_tdm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int INCR_WIDTH  = 8,
    parameter int NUM_CH      = 4,
    parameter int FINAL_COUNT = 2**INCR_WIDTH - 1,
    parameter int PIPE_STAGES = 3,
    parameter int SIGNED_A    = 0,
    localparam int CH_W       = ch_width(NUM_CH),
    localparam int PW         = WIDTH + INCR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    coef_clr,
    input  logic [NUM_CH*WIDTH-1:0] din,
    output logic [PW-1:0]           dout,
    output logic [CH_W-1:0]         dout_ch,
    output logic                    dout_valid
);

    localparam logic [INCR_WIDTH-1:0] FINAL_C = INCR_WIDTH'(FINAL_COUNT);

    logic [CH_W-1:0]       grant;
    logic                  grant_valid;
    logic [WIDTH-1:0]      din_arr [NUM_CH];
    logic [INCR_WIDTH-1:0] coef_q  [NUM_CH];
    logic [INCR_WIDTH-1:0] coef_d  [NUM_CH];
    pipe_rec_t             tag_q   [PIPE_STAGES];
    pipe_rec_t             tag_d   [PIPE_STAGES];
    logic [WIDTH-1:0]      a0_q, a0_d;
    logic [INCR_WIDTH-1:0] b0_q, b0_d;
    logic [WIDTH-1:0]      a_m;
    logic [INCR_WIDTH-1:0] b_m;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         p_in;
    logic [PW-1:0]         p_q, p_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_din
        assign din_arr[g] = din[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ch_en       (ch_en),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Granted counter steps after use; clear wins over the step and hits every channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            coef_d[i] = coef_q[i];
        end
        if (coef_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                coef_d[i] = '0;
            end
        end else if (grant_valid) begin
            if (coef_q[grant] == FINAL_C) begin
                coef_d[grant] = '0;
            end else begin
                coef_d[grant] = coef_q[grant] + INCR_WIDTH'(1);
            end
        end
    end

    // Coefficient counter bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

    // Tag/valid shift register, same depth as the data path.
    always_comb begin
        tag_d[0].valid = grant_valid;
        tag_d[0].tag   = ch_tag_t'(grant);
        for (int s = 1; s < PIPE_STAGES; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // Tag/valid registers; reset flushes every in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Stage 0 operand capture from the granted channel; holds across bubbles.
    always_comb begin
        a0_d = a0_q;
        b0_d = b0_q;
        if (grant_valid) begin
            a0_d = din_arr[grant];
            b0_d = coef_q[grant];
        end
    end

    // Stage 0 operand registers (DSP A/B input registers).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q <= '0;
            b0_q <= '0;
        end else begin
            a0_q <= a0_d;
            b0_q <= b0_d;
        end
    end

    if (PIPE_STAGES == 4) begin : g_pre
        logic [WIDTH-1:0]      a1_q, a1_d;
        logic [INCR_WIDTH-1:0] b1_q, b1_d;

        // Second operand register in the pre-adder position.
        always_comb begin
            a1_d = a1_q;
            b1_d = b1_q;
            if (tag_q[0].valid) begin
                a1_d = a0_q;
                b1_d = b0_q;
            end
        end

        // Pre-adder position registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a1_q <= '0;
                b1_q <= '0;
            end else begin
                a1_q <= a1_d;
                b1_q <= b1_d;
            end
        end

        assign a_m = a1_q;
        assign b_m = b1_q;
    end else begin : g_no_pre
        assign a_m = a0_q;
        assign b_m = b0_q;
    end

    if (SIGNED_A != 0) begin : g_signed
        // Coefficient gets a zero sign bit so it always reads as non-negative.
        assign prod = PW'($signed(a_m) * $signed({1'b0, b_m}));
    end else begin : g_unsigned
        assign prod = PW'(a_m) * PW'(b_m);
    end

    if (PIPE_STAGES >= 3) begin : g_mreg
        logic [PW-1:0] m_q, m_d;

        // Multiply register loads only for real samples.
        always_comb begin
            m_d = m_q;
            if (tag_q[PIPE_STAGES-3].valid) begin
                m_d = prod;
            end
        end

        // Multiply (M) register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_q <= '0;
            end else begin
                m_q <= m_d;
            end
        end

        assign p_in = m_q;
    end else begin : g_no_mreg
        assign p_in = prod;
    end

    // Output register keeps its last product through bubbles.
    always_comb begin
        p_d = p_q;
        if (tag_q[PIPE_STAGES-2].valid) begin
            p_d = p_in;
        end
    end

    // Output (P) register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    if (CH_W < TAG_MAX_W) begin : g_tag_hi
        logic unused_tag_hi;
        assign unused_tag_hi = |tag_q[PIPE_STAGES-1].tag[TAG_MAX_W-1:CH_W];
    end

    assign dout       = p_q;
    assign dout_ch    = tag_q[PIPE_STAGES-1].tag[CH_W-1:0];
    assign dout_valid = tag_q[PIPE_STAGES-1].valid;

endmodule

// File: tb/tb_rr_tdm_mult_engine.sv
// tb/tb_rr_tdm_mult_engine.sv - directed self-checking bench for rr_tdm_mult_engine
module tb_rr_tdm_mult_engine;

    localparam int W  = 8;
    localparam int IW = 8;
    localparam int N  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           coef_clr;
    logic [N-1:0]   ch_en;
    logic [N*W-1:0] din;
    logic [W+IW-1:0] dout, dout_u;
    logic [1:0]     dout_ch, dout_ch_u;
    logic           dout_valid, dout_valid_u;

    int   checks   = 0;
    int   failures = 0;
    logic collect  = 1'b0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_u_q[$];
    logic [31:0] exp_u_q[$];

    always #5 clk = ~clk;

    // Signed-A engine with a short coefficient wrap.
    rr_tdm_mult_engine #(
        .WIDTH(W), .INCR_WIDTH(IW), .NUM_CH(N), .FINAL_COUNT(3),
        .PIPE_STAGES(3), .SIGNED_A(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .coef_clr(coef_clr),
        .din(din), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid)
    );

    // Default (unsigned, full-range counter) engine on the same stimulus.
    rr_tdm_mult_engine #(
        .WIDTH(W), .INCR_WIDTH(IW), .NUM_CH(N)
    ) u_dut_u (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .coef_clr(coef_clr),
        .din(din), .dout(dout_u), .dout_ch(dout_ch_u), .dout_valid(dout_valid_u)
    );

    always @(negedge clk) begin
        if (collect) begin
            if (dout_valid)   got_q.push_back({14'd0, dout_ch, dout});
            if (dout_valid_u) got_u_q.push_back({14'd0, dout_ch_u, dout_u});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_exp(input logic [1:0] ch, input logic [15:0] d);
        exp_q.push_back({14'd0, ch, d});
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq(tag, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_burst(input int n);
        collect = 1'b1;
        en = 1'b1;
        repeat (n) tick();
        en = 1'b0;
        repeat (3) tick();
        collect = 1'b0;
    endtask

    task automatic clear_cycle();
        en = 1'b0;
        coef_clr = 1'b1;
        tick();
        coef_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ch_en = 4'hF; coef_clr = 1'b0; din = '0;
        repeat (4) begin
            din = $urandom;
            coef_clr = ~coef_clr;
            tick();
        end
        check_eq("reset_dout", dout, 0);
        check_eq("reset_ch", dout_ch, 0);
        check_eq("reset_valid", dout_valid, 0);

        // Release with full rotation running from the very first edge.
        rst_n = 1'b1;
        din = {8'd40, 8'd30, 8'd20, 8'd10};
        collect = 1'b1;
        tick();
        check_eq("lat_edge1_valid", dout_valid, 0);
        tick();
        check_eq("lat_edge2_valid", dout_valid, 0);
        tick();
        check_eq("lat_edge3_valid", dout_valid, 1);
        check_eq("first_ch", dout_ch, 0);
        check_eq("first_dout", dout, 0);
        repeat (9) tick();
        en = 1'b0;
        repeat (3) tick();
        collect = 1'b0;
        add_exp(0, 0);  add_exp(1, 0);  add_exp(2, 0);  add_exp(3, 0);
        add_exp(0, 10); add_exp(1, 20); add_exp(2, 30); add_exp(3, 40);
        add_exp(0, 20); add_exp(1, 40); add_exp(2, 60); add_exp(3, 80);
        check_stream("rotation");

        // Masked rotation over channels 0 and 2.
        clear_cycle();
        ch_en = 4'b0101;
        din = {8'd0, 8'd9, 8'd11, 8'd7};
        run_burst(6);
        add_exp(0, 0); add_exp(2, 0); add_exp(0, 7);
        add_exp(2, 9); add_exp(0, 14); add_exp(2, 18);
        check_stream("mask");

        // Re-enable ch1: it starts from coefficient 0; ch0 wraps after 3.
        ch_en = 4'b0111;
        run_burst(5);
        add_exp(0, 21); add_exp(1, 0); add_exp(2, 27); add_exp(0, 0); add_exp(1, 11);
        check_stream("reenable");

        // Coefficient wrap at FINAL_COUNT=3.
        clear_cycle();
        ch_en = 4'b0001;
        din = {24'd0, 8'd5};
        run_burst(6);
        add_exp(0, 0); add_exp(0, 5); add_exp(0, 10);
        add_exp(0, 15); add_exp(0, 0); add_exp(0, 5);
        check_stream("wrap");

        // Bubble: en 1,0,1 gives one gap and the counter does not move in it.
        en = 1'b1; tick();
        en = 1'b0; tick();
        en = 1'b1; tick();
        en = 1'b0;
        check_eq("bubble_v0", dout_valid, 1);
        check_eq("bubble_d0", dout, 10);
        tick();
        check_eq("bubble_gap", dout_valid, 0);
        check_eq("bubble_hold", dout, 10);
        tick();
        check_eq("bubble_v1", dout_valid, 1);
        check_eq("bubble_d1", dout, 15);
        repeat (2) tick();

        // Clear during a grant: that product keeps the old coefficient.
        ch_en = 4'b0011;
        din = {16'd0, 8'd6, 8'd5};
        collect = 1'b1;
        en = 1'b1;
        repeat (4) tick();
        coef_clr = 1'b1;
        tick();
        coef_clr = 1'b0;
        repeat (3) tick();
        en = 1'b0;
        repeat (3) tick();
        collect = 1'b0;
        add_exp(1, 0); add_exp(0, 0); add_exp(1, 6); add_exp(0, 5);
        add_exp(1, 12); add_exp(0, 0); add_exp(1, 0); add_exp(0, 5);
        check_stream("clear");

        // Signed A on u_dut, unsigned on u_dut_u, same sample 8'hFE.
        clear_cycle();
        got_u_q.delete();
        ch_en = 4'b0001;
        din = {24'd0, 8'hFE};
        run_burst(4);
        add_exp(0, 16'h0000); add_exp(0, 16'hFFFE); add_exp(0, 16'hFFFC); add_exp(0, 16'hFFFA);
        check_stream("signed");
        exp_u_q = '{32'h0000, 32'h00FE, 32'h01FC, 32'h02FA};
        check_eq("unsigned_count", got_u_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("unsigned", (i < got_u_q.size()) ? got_u_q[i] : 32'hDEAD_BEEF, exp_u_q[i]);
        end

        // Reset mid-stream flushes the pipeline.
        ch_en = 4'hF;
        din = {8'd40, 8'd30, 8'd20, 8'd10};
        en = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", dout_valid, 0);
        check_eq("midrst_dout", dout, 0);
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        collect = 1'b1;
        repeat (5) tick();
        collect = 1'b0;
        check_eq("no_stale", got_q.size(), 0);
        got_q.delete();
        got_u_q.delete();
        ch_en = 4'b0001;
        din = {24'd0, 8'd5};
        en = 1'b1;
        repeat (3) tick();
        check_eq("post_rst_valid", dout_valid, 1);
        check_eq("post_rst_ch", dout_ch, 0);
        check_eq("post_rst_dout", dout, 0);
        tick();
        check_eq("post_rst_next", dout, 5);
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
